// File: rtl/host_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : host_key_decoder
//  Description : PS/2 set-2 scancode parser for the Tom movement controller.
//                Tracks F0 (break) and E0 (extended) prefixes with a timeout,
//                keeps per-key held flags, and produces registered
//                left/right/jump levels (last-pressed direction wins) plus a
//                one-cycle game_reset pulse on a fresh press of R.
//                Optional: define ARROW_KEYS_EN to map E0 6B / E0 74 / E0 75
//                (left / right / up arrows) onto the left/right/jump sources.
//  Revision    : 1.0 - initial release
// ============================================================================
module host_key_decoder #(
  parameter int PREFIX_TIMEOUT = 1_000_000,
  parameter int CNT_W          = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       left,
  output logic       right,
  output logic       jump,
  output logic       game_reset
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_BREAK     = 2'd1,
    S_EXT       = 2'd2,
    S_EXT_BREAK = 2'd3
  } state_t;

  localparam logic             DIR_LEFT     = 1'b0;
  localparam logic             DIR_RIGHT    = 1'b1;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(PREFIX_TIMEOUT - 1);

  localparam logic [7:0] CODE_F0    = 8'hF0;
  localparam logic [7:0] CODE_E0    = 8'hE0;
  localparam logic [7:0] CODE_A     = 8'h1C;
  localparam logic [7:0] CODE_D     = 8'h23;
  localparam logic [7:0] CODE_W     = 8'h1D;
  localparam logic [7:0] CODE_SPACE = 8'h29;
  localparam logic [7:0] CODE_R     = 8'h2D;
`ifdef ARROW_KEYS_EN
  localparam logic [7:0] CODE_LARR  = 8'h6B;
  localparam logic [7:0] CODE_RARR  = 8'h74;
  localparam logic [7:0] CODE_UARR  = 8'h75;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             held_l_a_q, held_l_a_d;
  logic             held_r_d_q, held_r_d_d;
  logic             held_j_w_q, held_j_w_d;
  logic             held_j_sp_q, held_j_sp_d;
  logic             held_rst_q, held_rst_d;
`ifdef ARROW_KEYS_EN
  logic             held_l_arr_q, held_l_arr_d;
  logic             held_r_arr_q, held_r_arr_d;
  logic             held_j_up_q, held_j_up_d;
`endif
  logic             last_dir_q, last_dir_d;
  logic             left_q, left_d;
  logic             right_q, right_d;
  logic             jump_q, jump_d;
  logic             game_reset_q, game_reset_d;

  // Key event decode produced by the parser
  logic key_evt;     // a complete non-prefix byte arrived this cycle
  logic evt_ext;     // it was preceded by E0
  logic evt_brk;     // it was preceded by F0
  logic plain_evt;
  logic left_key;    // this event names a left-direction key
  logic right_key;   // this event names a right-direction key
  logic held_left_q, held_left_d;
  logic held_right_q, held_right_d;

  // Prefix parser and timeout counter next-state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    key_evt = 1'b0;
    evt_ext = 1'b0;
    evt_brk = 1'b0;
    if (rx_valid) begin
      cnt_d = '0;
      if (rx_data == CODE_F0) begin
        state_d = (state_q == S_EXT) ? S_EXT_BREAK : S_BREAK;
      end else if (rx_data == CODE_E0) begin
        state_d = S_EXT;
      end else begin
        state_d = S_IDLE;
        key_evt = 1'b1;
        evt_ext = (state_q == S_EXT) || (state_q == S_EXT_BREAK);
        evt_brk = (state_q == S_BREAK) || (state_q == S_EXT_BREAK);
      end
    end else if (state_q != S_IDLE) begin
      // A stale prefix is dropped; held flags are left alone
      if (cnt_q == TIMEOUT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Held-flag updates, direction arbitration and output next-values
  always_comb begin
    plain_evt   = key_evt & ~evt_ext;
    held_l_a_d  = held_l_a_q;
    held_r_d_d  = held_r_d_q;
    held_j_w_d  = held_j_w_q;
    held_j_sp_d = held_j_sp_q;
    held_rst_d  = held_rst_q;
    if (plain_evt) begin
      if (rx_data == CODE_A)     held_l_a_d  = ~evt_brk;
      if (rx_data == CODE_D)     held_r_d_d  = ~evt_brk;
      if (rx_data == CODE_W)     held_j_w_d  = ~evt_brk;
      if (rx_data == CODE_SPACE) held_j_sp_d = ~evt_brk;
      if (rx_data == CODE_R)     held_rst_d  = ~evt_brk;
    end
    left_key  = plain_evt && (rx_data == CODE_A);
    right_key = plain_evt && (rx_data == CODE_D);
`ifdef ARROW_KEYS_EN
    held_l_arr_d = held_l_arr_q;
    held_r_arr_d = held_r_arr_q;
    held_j_up_d  = held_j_up_q;
    if (key_evt && evt_ext) begin
      if (rx_data == CODE_LARR) held_l_arr_d = ~evt_brk;
      if (rx_data == CODE_RARR) held_r_arr_d = ~evt_brk;
      if (rx_data == CODE_UARR) held_j_up_d  = ~evt_brk;
    end
    left_key     = left_key  || (key_evt && evt_ext && (rx_data == CODE_LARR));
    right_key    = right_key || (key_evt && evt_ext && (rx_data == CODE_RARR));
    held_left_q  = held_l_a_q | held_l_arr_q;
    held_right_q = held_r_d_q | held_r_arr_q;
    held_left_d  = held_l_a_d | held_l_arr_d;
    held_right_d = held_r_d_d | held_r_arr_d;
    jump_d       = held_j_w_d | held_j_sp_d | held_j_up_d;
`else
    held_left_q  = held_l_a_q;
    held_right_q = held_r_d_q;
    held_left_d  = held_l_a_d;
    held_right_d = held_r_d_d;
    jump_d       = held_j_w_d | held_j_sp_d;
`endif
    // Only a fresh press of a direction claims priority; repeats do not
    last_dir_d = last_dir_q;
    if (left_key && !evt_brk && !held_left_q)   last_dir_d = DIR_LEFT;
    if (right_key && !evt_brk && !held_right_q) last_dir_d = DIR_RIGHT;
    left_d       = held_left_d  & (~held_right_d | (last_dir_d == DIR_LEFT));
    right_d      = held_right_d & (~held_left_d  | (last_dir_d == DIR_RIGHT));
    game_reset_d = plain_evt && !evt_brk && (rx_data == CODE_R) && !held_rst_q;
  end

  // State, flag and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      held_l_a_q   <= 1'b0;
      held_r_d_q   <= 1'b0;
      held_j_w_q   <= 1'b0;
      held_j_sp_q  <= 1'b0;
      held_rst_q   <= 1'b0;
`ifdef ARROW_KEYS_EN
      held_l_arr_q <= 1'b0;
      held_r_arr_q <= 1'b0;
      held_j_up_q  <= 1'b0;
`endif
      last_dir_q   <= DIR_RIGHT;
      left_q       <= 1'b0;
      right_q      <= 1'b0;
      jump_q       <= 1'b0;
      game_reset_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      held_l_a_q   <= held_l_a_d;
      held_r_d_q   <= held_r_d_d;
      held_j_w_q   <= held_j_w_d;
      held_j_sp_q  <= held_j_sp_d;
      held_rst_q   <= held_rst_d;
`ifdef ARROW_KEYS_EN
      held_l_arr_q <= held_l_arr_d;
      held_r_arr_q <= held_r_arr_d;
      held_j_up_q  <= held_j_up_d;
`endif
      last_dir_q   <= last_dir_d;
      left_q       <= left_d;
      right_q      <= right_d;
      jump_q       <= jump_d;
      game_reset_q <= game_reset_d;
    end
  end

  assign left       = left_q;
  assign right      = right_q;
  assign jump       = jump_q;
  assign game_reset = game_reset_q;

endmodule
`default_nettype wire

// File: tb/tb_host_key_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_host_key_decoder
//  Description : Directed self-checking bench for host_key_decoder. Uses a
//                short prefix timeout so the timeout path is reachable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_host_key_decoder;

  localparam int TIMEOUT = 20;

  logic       clk;
  logic       rst;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       left;
  logic       right;
  logic       jump;
  logic       game_reset;

  int n_cmp;
  int n_err;

  host_key_decoder #(
    .PREFIX_TIMEOUT(TIMEOUT),
    .CNT_W         (20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .left      (left),
    .right     (right),
    .jump      (jump),
    .game_reset(game_reset)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // One-cycle strobe; returns at the negedge where the byte's effect is visible
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    logic exp_arrow;
`ifdef ARROW_KEYS_EN
    exp_arrow = 1'b1;
`else
    exp_arrow = 1'b0;
`endif
    n_cmp    = 0;
    n_err    = 0;
    rst      = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(2);
    rst = 1'b0;
    idle(2);
    check("reset_left",  left,       1'b0);
    check("reset_right", right,      1'b0);
    check("reset_jump",  jump,       1'b0);
    check("reset_grst",  game_reset, 1'b0);

    // A press and release
    send(8'h1C);           check("a_make_left",  left,  1'b1);
                           check("a_make_right", right, 1'b0);
    send(8'hF0);           check("a_f0_left",    left,  1'b1);
    send(8'h1C);           check("a_brk_left",   left,  1'b0);
                           check("a_brk_right",  right, 1'b0);

    // Last-pressed-wins: A held, D pressed then released
    send(8'h1C);           check("ad_a_left",    left,  1'b1);
    send(8'h23);           check("ad_d_right",   right, 1'b1);
                           check("ad_d_left",    left,  1'b0);
    send(8'h1C);           check("ad_rep_right", right, 1'b1); // repeat of A keeps D
    send(8'hF0); send(8'h23);
                           check("ad_drel_left",  left,  1'b1);
                           check("ad_drel_right", right, 1'b0);
    send(8'hF0); send(8'h1C);
                           check("ad_arel_left", left,  1'b0);

    // D held, A wins, A released -> right returns
    send(8'h23);           check("da_d_right",   right, 1'b1);
    send(8'h1C);           check("da_a_left",    left,  1'b1);
                           check("da_a_right",   right, 1'b0);
    send(8'hF0); send(8'h1C);
                           check("da_arel_right", right, 1'b1);
                           check("da_arel_left",  left,  1'b0);
    send(8'hF0); send(8'h23);
                           check("da_drel_right", right, 1'b0);

    // R: pulse only on fresh press
    send(8'h2D);           check("r1_pulse", game_reset, 1'b1);
    idle(1);               check("r1_end",   game_reset, 1'b0);
    send(8'h2D);           check("r2_rep",   game_reset, 1'b0);
    send(8'h2D);           check("r3_rep",   game_reset, 1'b0);
    send(8'hF0); send(8'h2D);
                           check("r_brk",    game_reset, 1'b0);
    send(8'h2D);           check("r4_pulse", game_reset, 1'b1);
    idle(1);               check("r4_end",   game_reset, 1'b0);
    send(8'hF0); send(8'h2D);

    // Jump keys and the prefix timeout
    send(8'h1D);           check("w_make",    jump, 1'b1);
    send(8'hF0); send(8'h1D);
                           check("w_brk",     jump, 1'b0);
    send(8'h29);           check("sp_make",   jump, 1'b1);
    send(8'hF0); idle(3); send(8'h29);
                           check("sp_brk_in_time", jump, 1'b0);
    send(8'hF0); idle(TIMEOUT + 5); send(8'h29);
                           check("sp_after_timeout", jump, 1'b1);
    send(8'hF0); send(8'h29);
                           check("sp_brk2",   jump, 1'b0);

    // Unknown codes are ignored
    send(8'hAA); send(8'hFA); send(8'hEE);
    check("unk_left",  left,  1'b0);
    check("unk_right", right, 1'b0);
    check("unk_jump",  jump,  1'b0);

    // Extended arrow sequences
    send(8'hE0); send(8'h6B);
    check("larr_make", left, exp_arrow);
    send(8'hE0); send(8'hF0); send(8'h6B);
    check("larr_brk",  left, 1'b0);
    send(8'hE0); send(8'h74);
    check("rarr_make", right, exp_arrow);
    send(8'hE0); send(8'hF0); send(8'h74);
    check("rarr_brk",  right, 1'b0);
    send(8'hE0); send(8'h75);
    check("uarr_make", jump, exp_arrow);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("uarr_brk",  jump, 1'b0);

    // Parser back in IDLE, and an extended break must not clear a plain key
    send(8'h1C);           check("post_ext_make",  left, 1'b1);
    send(8'hE0); send(8'hF0); send(8'h1C);
                           check("ext_brk_not_plain", left, 1'b1);
    send(8'hF0); send(8'h1C);
                           check("final_rel", left, 1'b0);

    // Reset clears held state mid-press
    send(8'h23);           check("pre_rst_right", right, 1'b1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
                           check("post_rst_right", right, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/host_key_decoder.md
Name: host_key_decoder

Overview:
- Upstream stage of the Tom movement controller. Consumes the PS/2 set-2 scancode byte stream from the keyboard receiver.
- Produces level signals left/right/jump and a one-cycle game_reset pulse. These feed the controller's left/right/jump/reset inputs directly.
- Tracks make/break and E0-extended prefixes.
- Resolves left+right conflicts as last-pressed-wins, so downstream always sees a single direction.

Parameters:
- PREFIX_TIMEOUT, 1_000_000, clk cycles a prefix state (after F0/E0) waits for its next byte before it is discarded.
- CNT_W, 20, width of the timeout counter; must hold PREFIX_TIMEOUT.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a complete received byte
- rx_data  in  8  scancode byte
- left  out  1  move-left level
- right  out  1  move-right level
- jump  out  1  jump level, high while a jump key is held
- game_reset  out  1  one-cycle pulse on a fresh press of R

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. rst has priority over rx_valid. All outputs reset to 0. State resets to IDLE, all held flags to 0, last_dir to RIGHT, counter to 0.
- Parser FSM states: IDLE, BREAK (F0 seen), EXT (E0 seen), EXT_BREAK (E0 F0 seen).
  - IDLE: F0->BREAK; E0->EXT; other byte = make of plain code -> IDLE.
  - EXT: F0->EXT_BREAK; E0->EXT (counter restarts); other byte = extended make -> IDLE.
  - BREAK: F0->BREAK, E0->EXT (restart); other byte = plain break -> IDLE.
  - EXT_BREAK: F0->BREAK, E0->EXT (restart); other byte = extended break -> IDLE.
- Timeout:
  - Counter clears on every rx_valid and increments each cycle in non-IDLE states.
  - When it reaches PREFIX_TIMEOUT-1 without rx_valid, FSM -> IDLE and the prefix is dropped; held flags are unchanged.
- Plain key map (make sets the flag, break clears it):
  - 1C (A) -> held_l_a
  - 23 (D) -> held_r_d
  - 1D (W) and 29 (Space) -> separate jump flags
  - 2D (R) -> held_rst
- Unknown codes (incl. AA, FA, EE) are ignored, with no flag change.
- Typematic repeats (repeated makes) are idempotent.
- held_left = OR of left sources; held_right = OR of right sources; jump = OR of jump flags.
- last_dir:
  - Updated on a make of a direction key whose combined held flag was previously 0.
  - If left and right makes complete in the same cycle (impossible with single stream), no special case is needed.
- Output equations (registered, 1-cycle latency after the final byte's rx_valid):
  - left = held_left & (~held_right | last_dir==LEFT)
  - right = held_right & (~held_left | last_dir==RIGHT)
  - left and right are never both 1.
- Release of the winning key while the other is held: the other direction asserts on the next cycle.
- game_reset:
  - High for exactly one cycle, the cycle after a make of 2D when held_rst was 0.
  - Repeats produce no further pulse until a break of 2D is seen.

Optional Feature:
- ARROW_KEYS_EN defined:
  - Extended codes E0 6B (left arrow), E0 74 (right arrow) and E0 75 (up arrow) drive additional left/right/jump source flags, with make/break identical to plain keys.
  - They participate in last_dir and the OR terms.
- Undefined:
  - Extended sequences are still fully parsed, so no FSM change, but are ignored.
  - E0 F0 6B must never be interpreted as a plain break.

Test Plan:
1. rst=1 for 2 cycles, then idle -> left=right=jump=game_reset=0, FSM IDLE.
2. Bytes 1C, then F0 1C -> left=1 one cycle after the 1C strobe, left=0 one cycle after the second 1C strobe, right stays 0.
3. 1C, 23, F0 23 -> left=1, then right=1/left=0 after the 23 make, then left=1 again after the 23 break.
4. 2D, 2D, 2D, F0 2D, 2D -> exactly two single-cycle game_reset pulses, one after the first and one after the final 2D.
5. F0 followed by no byte for PREFIX_TIMEOUT cycles, then 29 -> jump=1; the 29 is treated as a make, not a break.
6. E0 6B then E0 F0 6B:
   - with ARROW_KEYS_EN: left pulses 1 then 0;
   - without ARROW_KEYS_EN: all outputs stay 0 and the FSM returns to IDLE after each sequence.
